// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - 4-digit multiplexed seven-segment scan controller
// Double-buffered content applied at frame boundaries, dead-time and PWM digit strobing.
module seven_seg_scan_ctrl #(
    parameter int PRESCALE = 16384,
    parameter int DEAD     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_blank,
    input  logic [3:0]  brightness,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_start
);
    localparam int SCW = $clog2(PRESCALE);
    localparam logic [SCW-1:0] SC_LAST = SCW'(PRESCALE - 1);
    localparam logic [SCW-1:0] SC_DEAD = SCW'(DEAD);

    logic [SCW-1:0] sc;
    logic [1:0]     di;
    logic           first;
    logic [15:0]    act_data;
    logic [3:0]     act_blank;
    logic [3:0]     act_bright;
    logic [15:0]    pend_data;
    logic [3:0]     pend_blank;
    logic           pend_full;

    logic           boundary;
    logic           xfer;
    logic           lit;
    logic [3:0]     nib;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h7E;
            4'h1: hex7 = 7'h30;
            4'h2: hex7 = 7'h6D;
            4'h3: hex7 = 7'h79;
            4'h4: hex7 = 7'h33;
            4'h5: hex7 = 7'h5B;
            4'h6: hex7 = 7'h5F;
            4'h7: hex7 = 7'h70;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h7B;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h1F;
            4'hC: hex7 = 7'h4E;
            4'hD: hex7 = 7'h3D;
            4'hE: hex7 = 7'h4F;
            default: hex7 = 7'h47;
        endcase
    endfunction

    // The cycle right after reset release counts as a boundary so fresh content can land at once.
    assign boundary   = first || ((sc == SC_LAST) && (di == 2'd3));
    assign xfer       = load_valid && !pend_full;
    assign load_ready = !pend_full;

    always_comb begin
        nib = act_data[{di, 2'b00} +: 4];
        lit = !act_blank[di] && (sc >= SC_DEAD) &&
              ((act_bright == 4'hF) || (sc[3:0] < act_bright));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc          <= '0;
            di          <= 2'd0;
            first       <= 1'b1;
            act_data    <= 16'h0000;
            act_blank   <= 4'hF;
            act_bright  <= 4'h0;
            pend_data   <= 16'h0000;
            pend_blank  <= 4'h0;
            pend_full   <= 1'b0;
            an          <= 4'h0;
            seg         <= 7'h00;
            frame_start <= 1'b0;
        end else begin
            sc          <= sc + 1'b1;
            if (sc == SC_LAST) begin
                di <= di + 2'd1;
            end
            first       <= 1'b0;
            frame_start <= boundary;
            an          <= lit ? (4'd1 << di) : 4'h0;
            seg         <= lit ? hex7(nib) : 7'h00;
            if (boundary) begin
                act_bright <= brightness;
            end
            // Apply and accept are exclusive: accepting needs pending empty, applying needs it full.
            if (boundary && pend_full) begin
                act_data  <= pend_data;
                act_blank <= pend_blank;
                pend_full <= 1'b0;
            end else if (xfer) begin
                pend_data  <= load_data;
                pend_blank <= load_blank;
                pend_full  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - self-checking bench for seven_seg_scan_ctrl
module tb_seven_seg_scan_ctrl;
    localparam int P     = 64;
    localparam int D     = 8;
    localparam int FRAME = 4 * P;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = 16'h0;
    logic [3:0]  load_blank = 4'h0;
    logic [3:0]  brightness = 4'h0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_start;

    seven_seg_scan_ctrl #(.PRESCALE(P), .DEAD(D)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_blank(load_blank), .brightness(brightness),
        .an(an), .seg(seg), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int tickno   = 0;

    logic [6:0] hex_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Reference model: position in the frame is derived from elapsed cycles since reset release.
    int          m_t;
    logic [15:0] m_ad, m_pd;
    logic [3:0]  m_ab, m_pb, m_br;
    logic        m_pf, m_acc;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_fs, e_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (tick %0d)", name, act, exp, tickno);
    endtask

    task automatic model_reset();
        m_t = 0; m_ad = 16'h0; m_pd = 16'h0; m_ab = 4'hF; m_pb = 4'h0;
        m_br = 4'h0; m_pf = 1'b0; m_acc = 1'b0;
    endtask

    task automatic model_step();
        int  sc, di, lvl;
        bit  bnd, on;
        sc  = m_t % P;
        di  = (m_t / P) % 4;
        bnd = (m_t == 0) || ((m_t % FRAME) == FRAME - 1);
        lvl = int'(m_br);
        on  = !m_ab[di] && (sc >= D) && ((lvl == 15) || ((sc % 16) < lvl));
        e_an  = on ? 4'(1 << di) : 4'h0;
        e_seg = on ? hex_tab[int'((m_ad >> (4 * di)) & 16'hF)] : 7'h00;
        e_fs  = bnd;
        m_acc = load_valid && !m_pf;
        if (bnd) m_br = brightness;
        if (bnd && m_pf) begin
            m_ad = m_pd; m_ab = m_pb; m_pf = 1'b0;
        end else if (m_acc) begin
            m_pd = load_data; m_pb = load_blank; m_pf = 1'b1;
        end
        e_rdy = !m_pf;
        m_t++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        tickno++;
        check("outputs{an,seg,fs,rdy}", 32'({an, seg, frame_start, load_ready}),
              32'({e_an, e_seg, e_fs, e_rdy}));
    endtask

    task automatic offer(input logic [15:0] d, input logic [3:0] b);
        bit ok = 0;
        load_valid = 1'b1; load_data = d; load_blank = b;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            if (m_acc) begin ok = 1; break; end
        end
        load_valid = 1'b0;
        if (!ok) check("offer_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_frame(output int waited);
        waited = -1;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            tick();
            if (frame_start) begin waited = i; break; end
        end
        if (waited < 0) check("frame_timeout", 32'(0), 32'(1));
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        load_valid = 1'b0;
        #1;
        check("async_rst_an", 32'(an), 32'(0));
        check("async_rst_seg", 32'(seg), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(load_ready), 32'(1));
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct packed {
        logic [15:0]      data;
        logic [3:0]       blank;
        logic [3:0]       br;
        logic [3:0][6:0]  exp_seg;
        logic [3:0][7:0]  exp_cnt;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int fs_ticks[$];
        int cnt [4];
        logic [6:0] last_seg [4];
        int waited, lit_cnt;

        vecs[0] = '{16'h12AF, 4'h0, 4'd15, {7'h30, 7'h6D, 7'h77, 7'h47}, {8'd56, 8'd56, 8'd56, 8'd56}};
        vecs[1] = '{16'h8888, 4'h0, 4'd4,  {7'h7F, 7'h7F, 7'h7F, 7'h7F}, {8'd12, 8'd12, 8'd12, 8'd12}};
        vecs[2] = '{16'h8888, 4'h0, 4'd0,  {7'h7F, 7'h7F, 7'h7F, 7'h7F}, {8'd0,  8'd0,  8'd0,  8'd0}};
        vecs[3] = '{16'h3C5E, 4'h5, 4'd10, {7'h79, 7'h4E, 7'h5B, 7'h4F}, {8'd32, 8'd0,  8'd32, 8'd0}};
        vecs[4] = '{16'h0D9B, 4'h8, 4'd9,  {7'h7E, 7'h3D, 7'h7B, 7'h1F}, {8'd0,  8'd28, 8'd28, 8'd28}};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_an", 32'(an), 32'(0));
        check("reset_seg", 32'(seg), 32'(0));
        check("reset_fs", 32'(frame_start), 32'(0));
        check("reset_ready", 32'(load_ready), 32'(1));
        rst = 1'b0;

        // Idle after reset: everything blanked, frame pulses on a fixed cadence.
        lit_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (frame_start) fs_ticks.push_back(tickno);
            if (an != 4'h0) lit_cnt++;
        end
        check("idle_dark", 32'(lit_cnt), 32'(0));
        check("idle_fs_count", 32'(fs_ticks.size()), 32'(3));
        if (fs_ticks.size() >= 3) begin
            check("first_boundary", 32'(fs_ticks[0]), 32'(1));
            check("first_period", 32'(fs_ticks[1] - fs_ticks[0]), 32'(FRAME - 1));
            check("frame_period", 32'(fs_ticks[2] - fs_ticks[1]), 32'(FRAME));
        end

        // Table-driven content/brightness/blank vectors measured over one whole frame.
        for (int v = 0; v < 5; v++) begin
            brightness = vecs[v].br;
            offer(vecs[v].data, vecs[v].blank);
            wait_frame(waited);
            for (int k = 0; k < 4; k++) begin cnt[k] = 0; last_seg[k] = 7'h00; end
            for (int i = 0; i < FRAME; i++) begin
                tick();
                for (int k = 0; k < 4; k++)
                    if (an == 4'(1 << k)) begin cnt[k]++; last_seg[k] = seg; end
            end
            for (int k = 0; k < 4; k++) begin
                check($sformatf("vec%0d_cnt_d%0d", v, k), 32'(cnt[k]), 32'(vecs[v].exp_cnt[k]));
                if (vecs[v].exp_cnt[k] != 0)
                    check($sformatf("vec%0d_seg_d%0d", v, k), 32'(last_seg[k]), 32'(vecs[v].exp_seg[k]));
            end
        end

        // Back-to-back offers: second stalls until the boundary frees pending.
        brightness = 4'd15;
        offer(16'h1111, 4'h0);
        load_valid = 1'b1; load_data = 16'h4444; load_blank = 4'h0;
        tick();
        check("b2b_ready_low", 32'(load_ready), 32'(0));
        wait_frame(waited);
        check("b2b_ready_rise", 32'(load_ready), 32'(1));
        tick();
        check("b2b_second_accept", 32'(m_acc), 32'(1));
        check("b2b_ready_low2", 32'(load_ready), 32'(0));
        load_valid = 1'b0;
        wait_frame(waited);

        // Offer landing exactly on a boundary edge is deferred a whole frame.
        for (int i = 0; i < FRAME && (m_t % FRAME) != FRAME - 1; i++) tick();
        load_valid = 1'b1; load_data = 16'h7777;
        tick();
        load_valid = 1'b0;
        check("coincide_fs", 32'(frame_start), 32'(1));
        check("coincide_captured", 32'(load_ready), 32'(0));
        last_seg[0] = 7'h00;
        waited = -1;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            tick();
            if (an[0]) last_seg[0] = seg;
            if (frame_start) begin waited = i; break; end
        end
        check("coincide_wait", 32'(waited), 32'(FRAME));
        check("coincide_old_value", 32'(last_seg[0]), 32'(7'h33));
        for (int i = 0; i < 100; i++) begin
            tick();
            if (an[0]) last_seg[0] = seg;
        end
        check("coincide_new_value", 32'(last_seg[0]), 32'(7'h70));

        // Reset while a digit is lit and a load is pending.
        offer(16'h5555, 4'h0);
        for (int i = 0; i < FRAME && an == 4'h0; i++) tick();
        check("pre_reset_lit", 32'(an != 4'h0), 32'(1));
        do_reset();
        lit_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (an != 4'h0) lit_cnt++;
        end
        check("post_reset_dark", 32'(lit_cnt), 32'(0));

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            load_valid = ($urandom_range(0, 3) == 0);
            load_data  = 16'($urandom);
            load_blank = 4'($urandom);
            if ($urandom_range(0, 63) == 0) brightness = 4'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
